fc_classifier: RTL and testbench

Fully-connected output stage directly downstream of the convolution top. It captures the 32 flattened layer-3 features streamed on the conv block's flat_out/addr_out/we_out bus and computes NUM_CLASS signed Q8.8 scores using a single time-multiplexed MAC. It streams each score out and reports the arg-max class index. Weights and biases load over the same shared data/addr/we host bus used by the conv weight memories, qualified by fc_weight.

---
 rtl/cnn_pkg.sv | 42 ++++
 rtl/fc_classifier_if.sv | 43 ++++
 rtl/fc_mac.sv | 49 ++++
 rtl/fc_classifier.sv | 199 +++++++++++++++++++
 tb/tb_fc_classifier.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN datapath blocks: fixed-point format,
// accumulator width, saturation limits, the fully-connected stage FSM
// state type and the helper that scales an accumulator back to Q8.8.
// No ports (package).
// ---------------------------------------------------------------------------
package cnn_pkg;

    localparam int DATA_W        = 16;
    localparam int FRAC          = 8;
    localparam int ACC_W         = 40;
    localparam int N_FEAT_DEF    = 32;
    localparam int NUM_CLASS_DEF = 10;

    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        STORE,
        DONE
    } fc_state_t;

    // Drops the fractional bits of an accumulator (arithmetic shift, so the
    // result rounds toward minus infinity) and clamps to the data range.
    function automatic logic signed [DATA_W-1:0] scale_sat(
        input logic signed [ACC_W-1:0] value
    );
        logic signed [ACC_W-1:0] shifted;
        shifted = value >>> FRAC;
        if (shifted > ACC_W'(SAT_MAX)) begin
            return SAT_MAX;
        end else if (shifted < ACC_W'(SAT_MIN)) begin
            return SAT_MIN;
        end else begin
            return DATA_W'(shifted);
        end
    endfunction

endpackage

// File: rtl/fc_classifier_if.sv
// ---------------------------------------------------------------------------
// fc_classifier_if
// Bundles the buses of the fully-connected classifier stage.
//   feature bus : flat_in, flat_addr, flat_we      (from the conv stage)
//   host bus    : data, addr, we, fc_weight        (weight/bias loading)
//   control     : srt_fc in; busy, done_fc out
//   results     : score_out, score_addr, score_we, class_out
// Modports: master drives the inputs and observes results, slave is the
// classifier itself.
// ---------------------------------------------------------------------------
interface fc_classifier_if;
    import cnn_pkg::*;

    logic signed [DATA_W-1:0] flat_in;
    logic [15:0]              flat_addr;
    logic                     flat_we;
    logic signed [DATA_W-1:0] data;
    logic [15:0]              addr;
    logic                     we;
    logic                     fc_weight;
    logic                     srt_fc;
    logic                     busy;
    logic                     done_fc;
    logic signed [DATA_W-1:0] score_out;
    logic [7:0]               score_addr;
    logic                     score_we;
    logic [7:0]               class_out;

    modport master (
        output flat_in, flat_addr, flat_we,
        output data, addr, we, fc_weight,
        output srt_fc,
        input  busy, done_fc, score_out, score_addr, score_we, class_out
    );

    modport slave (
        input  flat_in, flat_addr, flat_we,
        input  data, addr, we, fc_weight,
        input  srt_fc,
        output busy, done_fc, score_out, score_addr, score_we, class_out
    );

endinterface

// File: rtl/fc_mac.sv
// ---------------------------------------------------------------------------
// fc_mac
// Single multiply-accumulate lane for the classifier. Accumulates full-width
// signed products of feature x weight and presents the biased, scaled and
// saturated score of the current accumulator contents.
// Ports:
//   clk, reset   : clock, async active-high reset
//   clr          : zero the accumulator (wins over en)
//   en           : add feat*weight into the accumulator
//   feat, weight : signed Q8.8 operands
//   bias         : signed Q8.8 bias of the class being scored
//   score        : saturated Q8.8 score (combinational)
// ---------------------------------------------------------------------------
module fc_mac
    import cnn_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] feat,
    input  logic signed [DATA_W-1:0] weight,
    input  logic signed [DATA_W-1:0] bias,
    output logic signed [DATA_W-1:0] score
);

    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    biased;

    assign product = feat * weight;

    // Accumulator: the product is Q16.16, so it is sign-extended and summed
    // directly; the bias is lifted into the same format before the final
    // shift back down to Q8.8.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(product);
        end
    end

    assign biased = acc + (ACC_W'(bias) <<< FRAC);
    assign score  = scale_sat(biased);

endmodule

// File: rtl/fc_classifier.sv
// ---------------------------------------------------------------------------
// fc_classifier
// Fully-connected output stage. Captures the flattened features from the
// conv stage, holds host-loaded weights and biases, and computes one score
// per class with a single time-multiplexed MAC. Each score is streamed out
// with a one-cycle strobe and the arg-max class index is tracked.
// Ports:
//   clk, reset : clock, async active-high reset
//   bus        : fc_classifier_if.slave (feature bus, host bus, srt_fc,
//                busy/done_fc, score stream, class_out)
// ---------------------------------------------------------------------------
module fc_classifier
    import cnn_pkg::*;
#(
    parameter int N_FEAT    = N_FEAT_DEF,
    parameter int NUM_CLASS = NUM_CLASS_DEF
)
(
    input  logic            clk,
    input  logic            reset,
    fc_classifier_if.slave  bus
);

    localparam int W_DEPTH = NUM_CLASS * N_FEAT;
    localparam int FA_W    = $clog2(N_FEAT);
    localparam int FC_W    = $clog2(N_FEAT + 1);
    localparam int WA_W    = $clog2(W_DEPTH);
    localparam int CA_W    = $clog2(NUM_CLASS);

    logic signed [DATA_W-1:0] feat_mem [N_FEAT];
    logic signed [DATA_W-1:0] w_mem    [W_DEPTH];
    logic signed [DATA_W-1:0] bias_mem [NUM_CLASS];

    fc_state_t                state;
    fc_state_t                state_nxt;
    logic [CA_W-1:0]          cls;
    logic [FC_W-1:0]          feat_idx;
    logic [WA_W-1:0]          w_idx;
    logic                     last_feat;
    logic                     last_cls;
    logic                     busy;
    logic                     done;
    logic                     score_we;
    logic                     acc_clr;
    logic                     rd_issue;
    logic                     rd_valid;
    logic signed [DATA_W-1:0] feat_rd;
    logic signed [DATA_W-1:0] w_rd;
    logic signed [DATA_W-1:0] mac_score;
    logic signed [DATA_W-1:0] best;
    logic [7:0]               class_q;
    logic signed [DATA_W-1:0] score_q;
    logic [7:0]               score_addr_q;
    logic                     feat_wr;
    logic                     host_wr;
    logic                     host_w_hit;
    logic                     host_b_hit;

    assign last_feat = (feat_idx == FC_W'(N_FEAT));
    assign last_cls  = (cls == CA_W'(NUM_CLASS - 1));
    assign w_idx     = WA_W'(int'(cls) * N_FEAT + int'(feat_idx));

    // Both write ports are closed while a run is computing so the operands
    // cannot change underneath the MAC.
    assign feat_wr    = bus.flat_we && !busy && (bus.flat_addr < 16'(N_FEAT));
    assign host_wr    = bus.fc_weight && bus.we && !busy;
    assign host_w_hit = bus.addr < 16'(W_DEPTH);
    assign host_b_hit = (bus.addr >= 16'(W_DEPTH)) && (bus.addr < 16'(W_DEPTH + NUM_CLASS));

    // Next-state and control decode. MAC issues one read per feature and
    // spends one extra drain cycle so the last registered read is summed.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        score_we  = 1'b0;
        acc_clr   = 1'b0;
        rd_issue  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.srt_fc) begin
                    state_nxt = MAC;
                    acc_clr   = 1'b1;
                end
            end
            MAC: begin
                busy     = 1'b1;
                rd_issue = !last_feat;
                if (last_feat) begin
                    state_nxt = STORE;
                end
            end
            STORE: begin
                busy     = 1'b1;
                score_we = 1'b1;
                if (!last_cls) begin
                    acc_clr   = 1'b1;
                    state_nxt = MAC;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!bus.srt_fc) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register, class/feature counters and arg-max tracking. The first
    // class of a run always claims the maximum; later classes need a strictly
    // larger score, so ties resolve to the lowest index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cls          <= '0;
            feat_idx     <= '0;
            rd_valid     <= 1'b0;
            best         <= '0;
            class_q      <= '0;
            score_q      <= '0;
            score_addr_q <= '0;
        end else begin
            state    <= state_nxt;
            rd_valid <= rd_issue;
            unique case (state)
                IDLE: begin
                    if (bus.srt_fc) begin
                        cls      <= '0;
                        feat_idx <= '0;
                    end
                end
                MAC: begin
                    if (!last_feat) begin
                        feat_idx <= feat_idx + FC_W'(1);
                    end
                end
                STORE: begin
                    score_q      <= mac_score;
                    score_addr_q <= 8'(cls);
                    if ((cls == '0) || (mac_score > best)) begin
                        best    <= mac_score;
                        class_q <= 8'(cls);
                    end
                    if (!last_cls) begin
                        cls      <= cls + CA_W'(1);
                        feat_idx <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Storage: write ports for both buses plus the registered operand reads
    // that feed the MAC one cycle later. Contents survive reset.
    always_ff @(posedge clk) begin
        if (feat_wr) begin
            feat_mem[bus.flat_addr[FA_W-1:0]] <= bus.flat_in;
        end
        if (host_wr && host_w_hit) begin
            w_mem[bus.addr[WA_W-1:0]] <= bus.data;
        end
        if (host_wr && host_b_hit) begin
            bias_mem[CA_W'(bus.addr - 16'(W_DEPTH))] <= bus.data;
        end
        if (rd_issue) begin
            feat_rd <= feat_mem[feat_idx[FA_W-1:0]];
            w_rd    <= w_mem[w_idx];
        end
    end

    fc_mac u_mac (
        .clk    (clk),
        .reset  (reset),
        .clr    (acc_clr),
        .en     (rd_valid),
        .feat   (feat_rd),
        .weight (w_rd),
        .bias   (bias_mem[cls]),
        .score  (mac_score)
    );

    // The score bus shows the live result during STORE and otherwise holds
    // the last one written.
    assign bus.busy       = busy;
    assign bus.done_fc    = done;
    assign bus.score_we   = score_we;
    assign bus.score_out  = score_we ? mac_score : score_q;
    assign bus.score_addr = score_we ? 8'(cls) : score_addr_q;
    assign bus.class_out  = class_q;

endmodule

// File: tb/tb_fc_classifier.sv
// ---------------------------------------------------------------------------
// tb_fc_classifier
// Self-checking bench for fc_classifier. Keeps a plain-arithmetic model of
// the feature/weight/bias memories, computes every class score and the
// arg-max directly from the fixed-point rules, and compares the streamed
// results, latency and control outputs against it.
// ---------------------------------------------------------------------------
module tb_fc_classifier;
    import cnn_pkg::*;

    localparam int NF      = 32;
    localparam int NC      = 10;
    localparam int W_DEPTH = NF * NC;
    localparam int LAT     = NC * (NF + 2) + 1;

    logic clk = 1'b0;
    logic reset;

    fc_classifier_if bus ();

    fc_classifier #(.N_FEAT(NF), .NUM_CLASS(NC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int          feat_m [NF];
    int          w_m    [W_DEPTH];
    int          bias_m [NC];
    logic [15:0] exp_score [NC];
    int          exp_class;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rnd(input int lo, input int hi);
        int r;
        r = int'($urandom_range(32'(hi - lo))) + lo;
        return 16'(r);
    endfunction

    // Reference: dot product in Q16.16, add bias, floor-divide by 2^FRAC,
    // clamp, then pick the first class holding the largest score.
    function automatic void computeGolden();
        longint sum;
        longint s;
        longint best;
        for (int k = 0; k < NC; k++) begin
            sum = 0;
            for (int f = 0; f < NF; f++) begin
                sum += longint'(feat_m[f]) * longint'(w_m[k*NF + f]);
            end
            sum += longint'(bias_m[k]) * 256;
            s = sum >>> 8;
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
            exp_score[k] = 16'(s);
            if (k == 0 || s > best) begin
                best      = s;
                exp_class = k;
            end
        end
    endfunction

    task automatic writeFeat(input int a, input logic [15:0] v);
        bus.flat_addr = 16'(a);
        bus.flat_in   = v;
        bus.flat_we   = 1'b1;
        @(posedge clk);
        #1 bus.flat_we = 1'b0;
        if (a < NF) feat_m[a] = int'($signed(v));
    endtask

    task automatic writeHost(input int a, input logic [15:0] v);
        bus.addr      = 16'(a);
        bus.data      = v;
        bus.we        = 1'b1;
        bus.fc_weight = 1'b1;
        @(posedge clk);
        #1;
        bus.we        = 1'b0;
        bus.fc_weight = 1'b0;
        if (a < W_DEPTH) w_m[a] = int'($signed(v));
        else if (a < W_DEPTH + NC) bias_m[a - W_DEPTH] = int'($signed(v));
    endtask

    // Loads every feature, weight and bias according to a data pattern.
    task automatic applyStimulus(input int kind);
        logic [15:0] v;
        for (int f = 0; f < NF; f++) begin
            case (kind)
                1:       v = 16'h0100;
                2:       v = 16'h7FFF;
                4:       v = rnd(-1024, 1023);
                default: v = rnd(-32768, 32767);
            endcase
            writeFeat(f, v);
        end
        for (int a = 0; a < W_DEPTH; a++) begin
            case (kind)
                1:       v = 16'(16'h0040 * (a / NF));
                2:       v = (a / NF == 0) ? 16'h7FFF : (a / NF == 1) ? 16'h8000 : rnd(-128, 127);
                3:       v = 16'h0000;
                4:       v = rnd(-256, 255);
                default: v = rnd(-32768, 32767);
            endcase
            writeHost(a, v);
        end
        for (int k = 0; k < NC; k++) begin
            case (kind)
                3:       v = (k == 3 || k == 7) ? 16'h0005 : 16'h0000;
                4:       v = rnd(-2048, 2047);
                5:       v = rnd(-32768, 32767);
                default: v = 16'h0000;
            endcase
            writeHost(W_DEPTH + k, v);
        end
    endtask

    task automatic collectRun(input string tag);
        int  cyc;
        int  nstr;
        bit  got_done;
        cyc      = 0;
        nstr     = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 2 * LAT) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.score_we) begin
                checkOutput({tag, " score_addr"}, {24'b0, bus.score_addr}, 32'(nstr));
                checkOutput({tag, " score"}, {16'b0, bus.score_out}, {16'b0, exp_score[nstr % NC]});
                nstr++;
            end
            if (bus.done_fc) got_done = 1'b1;
        end
        checkOutput({tag, " done_seen"}, 32'(got_done), 32'd1);
        checkOutput({tag, " latency"}, 32'(cyc), 32'(LAT));
        checkOutput({tag, " strobes"}, 32'(nstr), 32'(NC));
        checkOutput({tag, " class_out"}, {24'b0, bus.class_out}, 32'(exp_class));
        checkOutput({tag, " busy_done"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic stopRun(input string tag);
        bus.srt_fc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " done_clear"}, 32'(bus.done_fc), 32'd0);
        checkOutput({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, " class_hold"}, {24'b0, bus.class_out}, 32'(exp_class));
    endtask

    initial begin
        logic [15:0] v;
        bus.flat_in   = '0;
        bus.flat_addr = '0;
        bus.flat_we   = 1'b0;
        bus.data      = '0;
        bus.addr      = '0;
        bus.we        = 1'b0;
        bus.fc_weight = 1'b0;
        bus.srt_fc    = 1'b0;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst busy", 32'(bus.busy), 32'd0);
        checkOutput("rst done", 32'(bus.done_fc), 32'd0);
        checkOutput("rst score_we", 32'(bus.score_we), 32'd0);
        checkOutput("rst score_out", {16'b0, bus.score_out}, 32'd0);
        checkOutput("rst score_addr", {24'b0, bus.score_addr}, 32'd0);
        checkOutput("rst class_out", {24'b0, bus.class_out}, 32'd0);
        reset = 1'b0;

        $display("[TB] ramp weights, hold start after completion, rerun");
        applyStimulus(1);
        computeGolden();
        bus.srt_fc = 1'b1;
        collectRun("ramp");
        repeat (20) begin
            @(negedge clk);
            checkOutput("hold done", 32'(bus.done_fc), 32'd1);
            checkOutput("hold no_score", 32'(bus.score_we), 32'd0);
        end
        stopRun("ramp");
        bus.srt_fc = 1'b1;
        collectRun("ramp rerun");
        stopRun("ramp rerun");

        $display("[TB] saturation");
        applyStimulus(2);
        computeGolden();
        bus.srt_fc = 1'b1;
        collectRun("sat");
        stopRun("sat");

        $display("[TB] tie on bias, start dropped mid-run");
        applyStimulus(3);
        computeGolden();
        bus.srt_fc = 1'b1;
        fork
            collectRun("tie");
            begin
                repeat (10) @(posedge clk);
                #1 bus.srt_fc = 1'b0;
            end
        join
        @(negedge clk);
        checkOutput("tie done_exit", 32'(bus.done_fc), 32'd0);
        checkOutput("tie class_hold", {24'b0, bus.class_out}, 32'(exp_class));

        $display("[TB] ignored writes: out-of-range and while busy");
        applyStimulus(4);
        writeFeat(40, rnd(-32768, 32767));
        writeHost(W_DEPTH + NC + 5, rnd(-32768, 32767));
        computeGolden();
        bus.srt_fc = 1'b1;
        fork
            collectRun("frozen");
            begin
                @(posedge clk);
                #1;
                repeat (100) begin
                    bus.flat_we   = 1'($urandom_range(1));
                    bus.flat_addr = 16'($urandom_range(NF - 1));
                    bus.flat_in   = rnd(-32768, 32767);
                    bus.we        = 1'($urandom_range(1));
                    bus.fc_weight = 1'b1;
                    bus.addr      = 16'($urandom_range(W_DEPTH + NC - 1));
                    bus.data      = rnd(-32768, 32767);
                    @(posedge clk);
                    #1;
                end
                bus.flat_we   = 1'b0;
                bus.we        = 1'b0;
                bus.fc_weight = 1'b0;
            end
        join
        stopRun("frozen");

        $display("[TB] reset mid-run then full run");
        applyStimulus(5);
        computeGolden();
        bus.srt_fc = 1'b1;
        repeat (50) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("midrst busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst score_we", 32'(bus.score_we), 32'd0);
        checkOutput("midrst class_out", {24'b0, bus.class_out}, 32'd0);
        checkOutput("midrst done", 32'(bus.done_fc), 32'd0);
        bus.srt_fc = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        bus.srt_fc = 1'b1;
        collectRun("after rst");
        stopRun("after rst");

        $display("[TB] feature write coincident with start");
        v = 16'(feat_m[0]) ^ 16'h2A5B;
        bus.flat_addr = 16'd0;
        bus.flat_in   = v;
        bus.flat_we   = 1'b1;
        bus.srt_fc    = 1'b1;
        feat_m[0]     = int'($signed(v));
        computeGolden();
        fork
            collectRun("coincident");
            begin
                @(posedge clk);
                #1 bus.flat_we = 1'b0;
            end
        join
        stopRun("coincident");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
